pool_result_writer: RTL and testbench
=====================================

// Module: pool_result_writer
// PURPOSE
//  Write-side partner of the max-pool control path. Captures each pooled result (qualified by
//  the pooler's op_en pulse), buffers it in a small FIFO, and writes it into the output
//  feature-map memory at raster address BASE_ADDR + row*(M/P) + col through a req/ack port.
//  Pulses frame_done once all (M/P)^2 results of a frame are committed to memory.
// PARAMETERS
//  M          4   input feature-map width/height (rows = cols)
//  P          2   pooling window size; M % P == 0 required
//  DATA_W     16  signed pooled-value width
//  ADDR_W     9   output memory address width
//  BASE_ADDR  0   address of first pooled result
//  FIFO_DEPTH 4   result FIFO entries (power of 2, >= 2)
// PORTS
//  clk         in   1       clock, all logic on rising edge
//  master_rst  in   1       synchronous active-low reset
//  start       in   1       1-cycle pulse: arm writer for a new frame
//  in_valid    in   1       pooled result valid (driven from pooler op_en)
//  in_data     in   DATA_W  pooled result, signed
//  wr_en       out  1       memory write request
//  wr_addr     out  ADDR_W  write address
//  wr_data     out  DATA_W  write data
//  wr_ack      in   1       memory accepted current request this cycle
//  busy        out  1       high from accepted start until frame_done cycle inclusive
//  frame_done  out  1       1-cycle pulse after last write acknowledged
//  overflow    out  1       sticky: a result was dropped this frame
// BEHAVIOUR
//  - Reset (master_rst=0 at edge): all outputs 0, FIFO empty, counters 0, state IDLE. Mid-frame
//    reset abandons the frame; no frame_done issued.
//  - FSM: IDLE -start-> RUN; RUN -(written==N)-> DONE; DONE -> IDLE (1 cycle). N=(M/P)^2.
//    start outside IDLE ignored. start in IDLE clears overflow, counters, col/row.
//  - Push: in_valid in RUN and accepted<N. Full FIFO with no pop same cycle -> drop, overflow<=1.
//    Full FIFO with pop same cycle -> push accepted. in_valid in IDLE/DONE or after N accepted
//    -> ignored and sets overflow.
//  - Write: wr_en=1 whenever FIFO non-empty in RUN; wr_data = FIFO head; wr_addr from col/row
//    counters. Pop and advance address on wr_en&&wr_ack. wr_en/addr/data held stable while
//    wr_ack=0. Back-to-back acks give one write per cycle.
//  - Latency: in_valid at edge t with empty FIFO -> wr_en high after edge t+1.
//  - Address: col 0..M/P-1, wraps to 0 and row++; wr_addr = BASE_ADDR + row*(M/P) + col,
//    truncated to ADDR_W. No wrap on row (bounded by N).
//  - frame_done: registered; high in DONE cycle (the cycle after final ack); busy falls after.
//  - wr_en=0 outside RUN; wr_ack with wr_en=0 ignored.
// CONFIGURATION
//  POOL_WR_RELU_EN defined: in_data < 0 stored as 0 (ReLU before FIFO push).
//  Undefined: in_data stored unmodified (signed passthrough).
// STRUCTURE
//  Package pool_pkg: state enum {IDLE,RUN,DONE}; function out_dim(M,P)=M/P; clog2 helper;
//  shared DATA_W default constant with the pooling datapath.
//  One sub-module: pool_wr_fifo (sync FIFO, push/pop/full/empty/head, same reset).
// TESTING (M=4,P=2,N=4,FIFO_DEPTH=4,BASE_ADDR=0x10 unless stated)
//  1 start; in_valid data 5,-3,7,9 on consecutive cycles, wr_ack=1 -> writes (0x10,5),
//    (0x11,-3),(0x12,7),(0x13,9); frame_done 1 cycle after last ack; overflow=0.
//  2 as 1 with wr_ack=0 for 3 cycles at first request -> wr_en/addr 0x10/data 5 held 3 cycles,
//    then all four written in order, no drop.
//  3 wr_ack=0; five in_valid pulses -> 4 stored, 5th dropped, overflow=1 until next start.
//  4 reset (master_rst=0) after 2 writes -> outputs 0, busy 0, no frame_done; new start
//    re-writes from 0x10.
//  5 start pulsed while busy -> ignored, address sequence unchanged; in_valid in IDLE -> overflow=1.
//  6 POOL_WR_RELU_EN defined, scenario 1 -> (0x11,0) written; others unchanged.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pool result writer and its pooling datapath.
package pool_pkg;

    localparam int unsigned POOL_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned out_dim(input int unsigned m, input int unsigned p);
        return m / p;
    endfunction

    // Bits needed to index v entries; never below 1 so vectors stay legal.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pool_wr_fifo.sv
// Synchronous result FIFO; exposes the head entry and the entry behind it so the
// writer can present the next word in the same cycle it retires the current one.
module pool_wr_fifo
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W = POOL_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  master_rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head_c,
    output logic [DATA_W-1:0]     next_head_c,
    output logic [clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_n;

    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_n = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!master_rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
            empty <= (count_n == '0);
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_c      = mem[rd_ptr];
    assign next_head_c = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/pool_result_writer.sv
// Buffers pooled results and writes them in raster order to the output feature map.
// Build option: define POOL_WR_RELU_EN to clamp negative results to 0 before buffering.
module pool_result_writer
    import pool_pkg::*;
#(
    parameter int unsigned M          = 4,
    parameter int unsigned P          = 2,
    parameter int unsigned DATA_W     = POOL_DATA_W,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);
    localparam int unsigned OD     = out_dim(M, P);
    localparam int unsigned N      = OD * OD;
    localparam int unsigned CNT_W  = clog2(N + 1);
    localparam int unsigned POS_W  = clog2(OD);
    localparam int unsigned FCNT_W = clog2(FIFO_DEPTH) + 1;

    state_t             state, state_n;
    logic [CNT_W-1:0]   accepted, accepted_n;
    logic [CNT_W-1:0]   written, written_n;
    logic [POS_W-1:0]   col, col_n;
    logic [POS_W-1:0]   row, row_n;
    logic               wr_en_n, busy_n, frame_done_n, overflow_n;
    logic [ADDR_W-1:0]  wr_addr_n;
    logic [DATA_W-1:0]  wr_data_n;
    logic [31:0]        addr_full;
    logic               start_acc, push, pop;
    logic [DATA_W-1:0]  push_data;
    logic [DATA_W-1:0]  head, next_head;
    logic [FCNT_W-1:0]  fifo_count;
    logic               fifo_full, fifo_empty;

`ifdef POOL_WR_RELU_EN
    assign push_data = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign push_data = in_data;
`endif

    pool_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .master_rst  (master_rst),
        .clr         (start_acc),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .head_c      (head),
        .next_head_c (next_head),
        .count       (fifo_count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // Next state plus look-ahead of every registered output.
    always_comb begin
        state_n    = state;
        start_acc  = (state == IDLE) && start;
        pop        = wr_en && wr_ack;
        push       = (state == RUN) && in_valid && (accepted < CNT_W'(N)) && (!fifo_full || pop);
        overflow_n = overflow | (in_valid && !push);
        accepted_n = accepted + CNT_W'(push);
        written_n  = written + CNT_W'(pop);
        col_n      = col;
        row_n      = row;

        if (pop) begin
            if (col == POS_W'(OD - 1)) begin
                col_n = '0;
                row_n = row + POS_W'(1);
            end else begin
                col_n = col + POS_W'(1);
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = RUN;
                    accepted_n = '0;
                    written_n  = '0;
                    col_n      = '0;
                    row_n      = '0;
                    overflow_n = 1'b0;
                end
            end
            RUN:     if (written_n == CNT_W'(N)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        addr_full    = 32'(BASE_ADDR) + 32'(row_n) * 32'(OD) + 32'(col_n);
        wr_addr_n    = ADDR_W'(addr_full);
        // A word pushed this cycle is presented one cycle later; only older entries count.
        wr_en_n      = (state_n == RUN) && !fifo_empty && !(pop && (fifo_count == FCNT_W'(1)));
        wr_data_n    = pop ? next_head : head;
        busy_n       = (state_n != IDLE);
        frame_done_n = (state_n == DONE);
    end

    always_ff @(posedge clk) begin
        if (!master_rst) begin
            state      <= IDLE;
            accepted   <= '0;
            written    <= '0;
            col        <= '0;
            row        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            accepted   <= accepted_n;
            written    <= written_n;
            col        <= col_n;
            row        <= row_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            overflow   <= overflow_n;
        end
    end

endmodule

// File: tb/tb_pool_result_writer.sv
// Self-checking bench for pool_result_writer: queue-based reference model compared
// every cycle, directed scenarios pinned with literal expectations, then random frames.
module tb_pool_result_writer;

    localparam int unsigned M     = 4;
    localparam int unsigned P     = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 9;
    localparam int unsigned BASE  = 16;
    localparam int unsigned DEPTH = 4;
    localparam int          N     = 4;

    logic          clk = 1'b0;
    logic          master_rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          wr_ack = 1'b0;
    logic          wr_en, busy, frame_done, overflow;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    pool_result_writer #(
        .M(M), .P(P), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .master_rst (master_rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of stored values; the k-th write lands at BASE+k.
    int            ph = 0;  // 0 idle, 1 running, 2 done
    logic [DW-1:0] q[$];
    int            written = 0;
    int            accepted = 0;
    logic          m_ov = 1'b0;
    logic          seen_rst = 1'b0;
    logic          e_wr_en = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_ov = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_data = '0;
    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];
    int            done_cnt = 0;

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef POOL_WR_RELU_EN
        return ($signed(d) < 0) ? '0 : d;
`else
        return d;
`endif
    endfunction

    always @(posedge clk) begin
        int visible;
        bit popped, pushed, was_full;
        visible = 0;
        if (wr_en && wr_ack) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (frame_done) done_cnt++;
        if (!master_rst) begin
            seen_rst = 1'b1;
            ph = 0;
            q.delete();
            written = 0;
            accepted = 0;
            m_ov = 1'b0;
        end else begin
            popped   = e_wr_en && wr_ack;
            was_full = (q.size() == DEPTH);
            pushed   = (ph == 1) && in_valid && (accepted < N) && (!was_full || popped);
            if (popped) begin
                void'(q.pop_front());
                written++;
            end
            visible = q.size();
            if (pushed) begin
                q.push_back(stored(in_data));
                accepted++;
            end else if (in_valid) begin
                m_ov = 1'b1;
            end
            case (ph)
                0: if (start) begin
                    ph = 1;
                    written = 0;
                    accepted = 0;
                    m_ov = 1'b0;
                    q.delete();
                end
                1: if (written == N) ph = 2;
                default: ph = 0;
            endcase
        end
        e_wr_en = (ph == 1) && (visible > 0);
        e_addr  = AW'(BASE + written);
        e_data  = (q.size() > 0) ? q[0] : '0;
        e_busy  = (ph != 0);
        e_done  = (ph == 2);
        e_ov    = m_ov;
    end

    always @(negedge clk) begin
        if (seen_rst) begin
            chk("cyc wr_en", wr_en, e_wr_en);
            chk("cyc busy", busy, e_busy);
            chk("cyc frame_done", frame_done, e_done);
            chk("cyc overflow", overflow, e_ov);
            if (e_wr_en) begin
                chk("cyc wr_addr", wr_addr, e_addr);
                chk("cyc wr_data", wr_data, e_data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        chk({name, " busy timeout"}, busy, 1'b0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] exp [4]);
        chk({name, " write count"}, log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk({name, " addr"}, log_addr[i], AW'(BASE + i));
            chk({name, " data"}, log_data[i], exp[i]);
        end
    endtask

    logic [DW-1:0] s1_exp [4];
    logic [DW-1:0] s3_exp [4];
    logic [DW-1:0] s5_exp [4];

    initial begin
`ifdef POOL_WR_RELU_EN
        s1_exp = '{16'd5, 16'd0, 16'd7, 16'd9};
`else
        s1_exp = '{16'd5, 16'hFFFD, 16'd7, 16'd9};
`endif
        s3_exp = '{16'd1, 16'd2, 16'd3, 16'd4};
        s5_exp = '{16'd21, 16'd22, 16'd23, 16'd24};

        // Reset state
        repeat (3) tick();
        chk("reset wr_en", wr_en, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset frame_done", frame_done, 1'b0);
        chk("reset overflow", overflow, 1'b0);
        chk("reset wr_addr", wr_addr, '0);
        chk("reset wr_data", wr_data, '0);
        master_rst = 1'b1;
        tick();

        // 1: basic frame, always acked
        clear_log();
        wr_ack = 1'b1;
        pulse_start();
        chk("s1 busy after start", busy, 1'b1);
        feed(16'd5); feed(16'hFFFD); feed(16'd7); feed(16'd9);
        wait_idle("s1", 30);
        check_log("s1", s1_exp);
        chk("s1 frame_done pulses", done_cnt, 1);
        chk("s1 overflow", overflow, 1'b0);

        // 2: first request stalled three cycles
        clear_log();
        wr_ack = 1'b0;
        pulse_start();
        feed(16'd5);
        for (int i = 1; i < 4; i++) begin
            feed(s1_exp[i] == 16'd0 ? 16'hFFFD : s1_exp[i]);
            chk("s2 held wr_en", wr_en, 1'b1);
            chk("s2 held addr", wr_addr, 9'h010);
            chk("s2 held data", wr_data, 16'd5);
        end
        wr_ack = 1'b1;
        wait_idle("s2", 30);
        check_log("s2", s1_exp);
        chk("s2 overflow", overflow, 1'b0);

        // 3: five results into a stalled four-deep FIFO
        clear_log();
        wr_ack = 1'b0;
        pulse_start();
        for (int i = 1; i <= 5; i++) feed(DW'(i));
        chk("s3 overflow set", overflow, 1'b1);
        wr_ack = 1'b1;
        wait_idle("s3", 30);
        check_log("s3", s3_exp);
        chk("s3 overflow sticky", overflow, 1'b1);
        pulse_start();
        chk("s3 overflow cleared", overflow, 1'b0);
        for (int i = 0; i < 4; i++) feed(DW'(40 + i));
        wait_idle("s3b", 30);

        // 4: reset after two writes abandons the frame
        clear_log();
        pulse_start();
        feed(16'd11); feed(16'd12); feed(16'd13); feed(16'd14);
        chk("s4 writes before reset", log_addr.size(), 2);
        master_rst = 1'b0;
        tick();
        chk("s4 reset wr_en", wr_en, 1'b0);
        chk("s4 reset busy", busy, 1'b0);
        chk("s4 reset wr_addr", wr_addr, '0);
        master_rst = 1'b1;
        repeat (5) tick();
        chk("s4 no frame_done", done_cnt, 0);
        clear_log();
        pulse_start();
        feed(16'd5); feed(16'hFFFD); feed(16'd7); feed(16'd9);
        wait_idle("s4", 30);
        check_log("s4", s1_exp);

        // 5: start while busy ignored; result while idle flags overflow
        clear_log();
        pulse_start();
        feed(16'd21);
        pulse_start();
        feed(16'd22); feed(16'd23);
        pulse_start();
        feed(16'd24);
        wait_idle("s5", 30);
        check_log("s5", s5_exp);
        chk("s5 frame_done pulses", done_cnt, 1);
        chk("s5 overflow before", overflow, 1'b0);
        feed(16'd99);
        tick();
        chk("s5 idle in_valid overflow", overflow, 1'b1);
        chk("s5 idle busy", busy, 1'b0);

        // Random frames with random acks, stray starts and occasional resets
        for (int f = 0; f < 40; f++) begin
            int k;
            if ($urandom_range(0, 3) == 0) feed(DW'($urandom));
            pulse_start();
            k = 0;
            do begin
                in_valid   = ($urandom_range(0, 1) == 1);
                in_data    = DW'($urandom);
                wr_ack     = ($urandom_range(0, 2) != 0);
                start      = ($urandom_range(0, 15) == 0);
                master_rst = ($urandom_range(0, 199) != 0);
                tick();
                k++;
            end while (busy && k < 300);
            chk("rand frame timeout", busy, 1'b0);
            in_valid   = 1'b0;
            start      = 1'b0;
            master_rst = 1'b1;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
